// File: rtl/pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl
//   Central stall/flush sequencer for the 5-stage 64-bit pipeline.
//   It handles three situations:
//     - multi-cycle data-memory access: the whole pipeline is frozen
//     - load-use hazard: IF/ID and PC are held, and a bubble is put into ID/EX
//     - taken branch: IF/ID, ID/EX and EX/MEM are flushed
//   It also keeps stall and flush performance counters.
//
// Parameters
//   MEM_LAT  cycles per data-memory access (>=1); 1 means no memory freeze
//   CNT_W    width of the performance counters
//
// Ports
//   clk             pipeline clock; all state changes on the rising edge
//   reset           synchronous, active-high
//   idex_memread    the ID/EX instruction is a load
//   idex_rd         destination register of the ID/EX instruction
//   ifid_rs1/rs2    source registers of the IF/ID instruction
//   exmem_memread   the EX/MEM instruction reads data memory
//   exmem_memwrite  the EX/MEM instruction writes data memory
//   branch_taken    a taken branch is resolved in the EX/MEM stage
//   pc_write        PC load enable
//   *_maintain      hold the named pipeline register
//   *_flush         the named pipeline register loads a bubble
//   mem_busy        the sequencer is waiting on data memory (MEM_WAIT)
//   stall_count     number of non-reset cycles with pc_write=0 (wraps)
//   flush_count     number of taken-branch flush events (wraps)
// -----------------------------------------------------------------------------
module pipeline_stall_ctrl #(
  parameter int MEM_LAT = 2,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             idex_memread,
  input  logic [4:0]       idex_rd,
  input  logic [4:0]       ifid_rs1,
  input  logic [4:0]       ifid_rs2,
  input  logic             exmem_memread,
  input  logic             exmem_memwrite,
  input  logic             branch_taken,
  output logic             pc_write,
  output logic             ifid_maintain,
  output logic             idex_maintain,
  output logic             exmem_maintain,
  output logic             memwb_maintain,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             mem_busy,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int CNT_BITS = $clog2(MEM_LAT) + 1;
  localparam bit HAS_WAIT = (MEM_LAT > 1);
  // The cycle that detects the access is the first frozen cycle, so the wait
  // state only has to cover the MEM_LAT-2 frozen cycles that remain.
  localparam logic [CNT_BITS-1:0] WAIT_LOAD =
    HAS_WAIT ? CNT_BITS'(MEM_LAT - 2) : '0;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } state_t;

  state_t              state;
  logic [CNT_BITS-1:0] cnt;

  logic memOp;
  logic loadUse;
  logic freeze;
  logic runRules;
  logic flushEvent;

  assign memOp   = exmem_memread | exmem_memwrite;
  assign loadUse = idex_memread && (idex_rd != 5'd0) &&
                   ((idex_rd == ifid_rs1) || (idex_rd == ifid_rs2));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    pc_write       = 1'b0;
    ifid_maintain  = 1'b0;
    idex_maintain  = 1'b0;
    exmem_maintain = 1'b0;
    memwb_maintain = 1'b0;
    ifid_flush     = 1'b0;
    idex_flush     = 1'b0;
    exmem_flush    = 1'b0;
    mem_busy       = 1'b0;
    freeze         = 1'b0;
    runRules       = 1'b0;

    if (reset) begin
      // Fill the pipeline with bubbles while reset is held.
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else begin
      case (state)
        RUN: begin
          if (memOp && HAS_WAIT) freeze = 1'b1;
          else                   runRules = 1'b1;
        end
        MEM_WAIT: begin
          mem_busy = 1'b1;
          // On the release cycle the same memory op is still in EX/MEM, so
          // only the branch / load-use / normal rules apply. The access must
          // not start again.
          if (cnt != '0) freeze = 1'b1;
          else           runRules = 1'b1;
        end
        default: runRules = 1'b1;
      endcase
    end

    if (freeze) begin
      // The MEM/WB hold re-presents the same writeback. That is harmless.
      ifid_maintain  = 1'b1;
      idex_maintain  = 1'b1;
      exmem_maintain = 1'b1;
      memwb_maintain = 1'b1;
    end

    if (runRules) begin
      if (branch_taken) begin
        pc_write    = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
      end else if (loadUse) begin
        ifid_maintain = 1'b1;
        idex_flush    = 1'b1;
      end else begin
        pc_write = 1'b1;
      end
    end
  end

  assign flushEvent = runRules & branch_taken;

  always_ff @(posedge clk) begin
    // NOTE: registered state uses non-blocking assignments only, so every
    // flop samples values from before the edge.
    if (reset) begin
      state       <= RUN;
      cnt         <= '0;
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      case (state)
        RUN: begin
          if (memOp && HAS_WAIT) begin
            state <= MEM_WAIT;
            cnt   <= WAIT_LOAD;
          end
        end
        MEM_WAIT: begin
          if (cnt != '0) cnt <= cnt - CNT_BITS'(1);
          else           state <= RUN;
        end
        default: state <= RUN;
      endcase

      if (!pc_write)  stall_count <= stall_count + CNT_W'(1);
      if (flushEvent) flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
//   Three copies of the sequencer (MEM_LAT = 1, 2, 3) share one input stream.
//   A behavioural model follows each memory op by its age in EX/MEM. Every
//   cycle, a single compare process checks all outputs of every copy against
//   that model. Directed scenarios add hand-computed literal checks, which
//   pin down the model itself.
// -----------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

  localparam int NDUT = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       idex_memread = 1'b0;
  logic [4:0] idex_rd = '0;
  logic [4:0] ifid_rs1 = '0;
  logic [4:0] ifid_rs2 = '0;
  logic       exmem_memread = 1'b0;
  logic       exmem_memwrite = 1'b0;
  logic       branch_taken = 1'b0;

  logic [NDUT-1:0] pcW, ifidM, idexM, exmemM, memwbM, ifidF, idexF, exmemF, busy;
  logic [31:0]     stallCnt [NDUT];
  logic [31:0]     flushCnt [NDUT];

  int total = 0;
  int bad   = 0;

  pipeline_stall_ctrl #(.MEM_LAT(1), .CNT_W(32)) u_dut1 (
    .clk(clk), .reset(reset), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .exmem_memread(exmem_memread),
    .exmem_memwrite(exmem_memwrite), .branch_taken(branch_taken),
    .pc_write(pcW[0]), .ifid_maintain(ifidM[0]), .idex_maintain(idexM[0]),
    .exmem_maintain(exmemM[0]), .memwb_maintain(memwbM[0]), .ifid_flush(ifidF[0]),
    .idex_flush(idexF[0]), .exmem_flush(exmemF[0]), .mem_busy(busy[0]),
    .stall_count(stallCnt[0]), .flush_count(flushCnt[0]));

  pipeline_stall_ctrl #(.MEM_LAT(2), .CNT_W(32)) u_dut2 (
    .clk(clk), .reset(reset), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .exmem_memread(exmem_memread),
    .exmem_memwrite(exmem_memwrite), .branch_taken(branch_taken),
    .pc_write(pcW[1]), .ifid_maintain(ifidM[1]), .idex_maintain(idexM[1]),
    .exmem_maintain(exmemM[1]), .memwb_maintain(memwbM[1]), .ifid_flush(ifidF[1]),
    .idex_flush(idexF[1]), .exmem_flush(exmemF[1]), .mem_busy(busy[1]),
    .stall_count(stallCnt[1]), .flush_count(flushCnt[1]));

  pipeline_stall_ctrl #(.MEM_LAT(3), .CNT_W(32)) u_dut3 (
    .clk(clk), .reset(reset), .idex_memread(idex_memread), .idex_rd(idex_rd),
    .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .exmem_memread(exmem_memread),
    .exmem_memwrite(exmem_memwrite), .branch_taken(branch_taken),
    .pc_write(pcW[2]), .ifid_maintain(ifidM[2]), .idex_maintain(idexM[2]),
    .exmem_maintain(exmemM[2]), .memwb_maintain(memwbM[2]), .ifid_flush(ifidF[2]),
    .idex_flush(idexF[2]), .exmem_flush(exmemF[2]), .mem_busy(busy[2]),
    .stall_count(stallCnt[2]), .flush_count(flushCnt[2]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output bundle order:
  // {pc_write, ifid_m, idex_m, exmem_m, memwb_m, ifid_f, idex_f, exmem_f, mem_busy}
  function automatic logic [8:0] actual(input int i);
    return {pcW[i], ifidM[i], idexM[i], exmemM[i], memwbM[i],
            ifidF[i], idexF[i], exmemF[i], busy[i]};
  endfunction

  // ---------------------------------------------------------------------------
  // Model. opAge counts how many cycles the current memory op has been
  // serviced in EX/MEM (0 = none). An access needs lat-1 frozen cycles, and
  // the cycle after that is the release cycle.
  // ---------------------------------------------------------------------------
  int          lat [NDUT] = '{1, 2, 3};
  int          opAge [NDUT];
  logic [31:0] mStall [NDUT];
  logic [31:0] mFlush [NDUT];

  always @(negedge clk) begin
    for (int i = 0; i < NDUT; i++) begin
      logic [8:0] exp;
      bit         normal;
      bit         mOp;
      bit         lu;
      mOp = exmem_memread | exmem_memwrite;
      lu  = idex_memread && idex_rd != 0 &&
            (idex_rd == ifid_rs1 || idex_rd == ifid_rs2);
      normal = 1'b0;
      check($sformatf("stall_count[lat=%0d]", lat[i]), 64'(stallCnt[i]), 64'(mStall[i]));
      check($sformatf("flush_count[lat=%0d]", lat[i]), 64'(flushCnt[i]), 64'(mFlush[i]));
      if (reset) begin
        exp = 9'b0_0000_111_0;
        opAge[i]  = 0;
        mStall[i] = '0;
        mFlush[i] = '0;
      end else begin
        if (opAge[i] == 0 && mOp && lat[i] > 1) begin
          exp = 9'b0_1111_000_0;
          opAge[i] = 1;
        end else if (opAge[i] > 0 && opAge[i] < lat[i] - 1) begin
          exp = 9'b0_1111_000_1;
          opAge[i]++;
        end else begin
          normal = 1'b1;
          exp = '0;
          if (opAge[i] > 0) begin
            exp[0]   = 1'b1;
            opAge[i] = 0;
          end
        end
        if (normal) begin
          if (branch_taken) begin
            exp[8] = 1'b1; exp[3:1] = 3'b111;
            mFlush[i] = mFlush[i] + 1;
          end else if (lu) begin
            exp[7] = 1'b1; exp[2] = 1'b1;
          end else begin
            exp[8] = 1'b1;
          end
        end
        if (!exp[8]) mStall[i] = mStall[i] + 1;
      end
      check($sformatf("outputs[lat=%0d]", lat[i]), 64'(actual(i)), 64'(exp));
    end
  end

  // Drive one cycle's inputs just after the rising edge, then wait until the
  // following falling edge, where the outputs of that cycle are sampled.
  task automatic cyc(input bit rst, input bit exr, input bit exw, input bit br,
                     input bit idr, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2);
    @(posedge clk);
    #1;
    reset          = rst;
    exmem_memread  = exr;
    exmem_memwrite = exw;
    branch_taken   = br;
    idex_memread   = idr;
    idex_rd        = rd;
    ifid_rs1       = rs1;
    ifid_rs2       = rs2;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic do_reset();
    cyc(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    cyc(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  // {exr, exw, br, idr, rd, rs1, rs2}: mixed vectors, including load-use and
  // branches that arrive while the pipeline is frozen.
  typedef struct packed {
    logic       exr, exw, br, idr;
    logic [4:0] rd, rs1, rs2;
  } vec_t;

  vec_t mix [12] = '{
    '{1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd1},
    '{1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd1},
    '{1'b1, 1'b0, 1'b0, 1'b1, 5'd7, 5'd7, 5'd1},
    '{1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd2, 5'd7},
    '{1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0},
    '{1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0},
    '{1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0},
    '{1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd3},
    '{1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 5'd4, 5'd8},
    '{1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 5'd9, 5'd9},
    '{1'b1, 1'b1, 1'b0, 1'b0, 5'd9, 5'd9, 5'd9},
    '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0}
  };

  initial begin
    int badCycles;
    // Reset state.
    @(negedge clk);
    check("rst pc_write", 64'(pcW), 64'(3'b000));
    check("rst flushes", 64'({ifidF, idexF, exmemF}), 64'(9'h1FF));
    check("rst mem_busy", 64'(busy), 64'(3'b000));
    do_reset();

    // T1: MEM_LAT=3, load in EX/MEM for three cycles.
    idle();
    check("t1 idle stall", 64'(stallCnt[2]), 64'(0));
    cyc(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    check("t1 c0 pc_write", 64'(pcW[2]), 64'(0));
    check("t1 c0 mem_busy", 64'(busy[2]), 64'(0));
    check("t1 c0 memwb_m", 64'(memwbM[2]), 64'(1));
    cyc(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    check("t1 c1 pc_write", 64'(pcW[2]), 64'(0));
    check("t1 c1 mem_busy", 64'(busy[2]), 64'(1));
    cyc(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    check("t1 c2 pc_write", 64'(pcW[2]), 64'(1));
    check("t1 c2 ifid_m", 64'(ifidM[2]), 64'(0));
    idle();
    check("t1 stall_count", 64'(stallCnt[2]), 64'(2));
    check("t1 lat1 stall_count", 64'(stallCnt[0]), 64'(0));

    // T2: load-use on rs2, then a load to x0, which must not stall.
    cyc(0, 0, 0, 0, 1, 5'd5, 5'd3, 5'd5);
    check("t2 pc_write", 64'(pcW[0]), 64'(0));
    check("t2 ifid_m", 64'(ifidM[0]), 64'(1));
    check("t2 idex_flush", 64'(idexF[0]), 64'(1));
    check("t2 idex_m", 64'(idexM[0]), 64'(0));
    cyc(0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    check("t2 x0 pc_write", 64'(pcW[0]), 64'(1));
    check("t2 x0 idex_flush", 64'(idexF[0]), 64'(0));

    // T3: taken branch in RUN.
    do_reset();
    check("t3 flush_count pre", 64'(flushCnt[0]), 64'(0));
    cyc(0, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0);
    check("t3 flushes", 64'({ifidF[0], idexF[0], exmemF[0]}), 64'(3'b111));
    check("t3 pc_write", 64'(pcW[0]), 64'(1));
    idle();
    check("t3 flush_count", 64'(flushCnt[0]), 64'(1));

    // T4: MEM_LAT=2, store plus branch: freeze first, then flush.
    do_reset();
    cyc(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
    check("t4 c1 pc_write", 64'(pcW[1]), 64'(0));
    check("t4 c1 exmem_flush", 64'(exmemF[1]), 64'(0));
    check("t4 c1 maintains", 64'({ifidM[1], idexM[1], exmemM[1], memwbM[1]}), 64'(4'hF));
    cyc(0, 0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
    check("t4 c2 flushes", 64'({ifidF[1], idexF[1], exmemF[1]}), 64'(3'b111));
    check("t4 c2 pc_write", 64'(pcW[1]), 64'(1));
    idle();
    check("t4 flush_count", 64'(flushCnt[1]), 64'(1));

    // T5: reset while MEM_LAT=3 sits in MEM_WAIT with one frozen cycle left.
    do_reset();
    cyc(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    cyc(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    check("t5 rst flushes", 64'({ifidF[2], idexF[2], exmemF[2]}), 64'(3'b111));
    check("t5 rst pc_write", 64'(pcW[2]), 64'(0));
    check("t5 rst mem_busy", 64'(busy[2]), 64'(0));
    idle();
    check("t5 mem_busy", 64'(busy[2]), 64'(0));
    check("t5 pc_write", 64'(pcW[2]), 64'(1));
    check("t5 stall_count", 64'(stallCnt[2]), 64'(0));
    check("t5 flush_count", 64'(flushCnt[2]), 64'(0));

    // T6: MEM_LAT=1, 100 back-to-back loads/stores, no hazards.
    do_reset();
    badCycles = 0;
    for (int k = 0; k < 100; k++) begin
      cyc(0, k[0], ~k[0], 0, 0, 5'd0, 5'd0, 5'd0);
      if (pcW[0] !== 1'b1 || busy[0] !== 1'b0) badCycles++;
    end
    check("t6 bad cycles", 64'(badCycles), 64'(0));
    idle();
    check("t6 stall_count", 64'(stallCnt[0]), 64'(0));

    // Mixed vectors; the per-cycle model comparison covers them.
    do_reset();
    foreach (mix[k])
      cyc(0, mix[k].exr, mix[k].exw, mix[k].br, mix[k].idr,
          mix[k].rd, mix[k].rs1, mix[k].rs2);
    idle();
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
